// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes and debounces encoder phases A/B and
// turns valid Gray-code steps into a wrapping up/down position count.
module quad_decoder #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam logic [0:0]       ST_INIT   = 1'b0;
  localparam logic [0:0]       ST_RUN    = 1'b1;
  localparam logic [7:0]       DB_LAST   = 8'(DEBOUNCE - 1);
  localparam logic [8:0]       INIT_LAST = 9'(DEBOUNCE + 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  // Returns {filtered level, counter}; a level is accepted after DEBOUNCE differing samples.
  function automatic logic [8:0] deb_next(input logic s, input logic f, input logic [7:0] c);
    logic [8:0] r;
    if (s == f) begin
      r = {f, 8'd0};
    end else if (c == DB_LAST) begin
      r = {s, 8'd0};
    end else begin
      r = {f, c + 8'd1};
    end
    return r;
  endfunction

  logic             a_meta_q, sa_q, b_meta_q, sb_q;
  logic             fa_q, fa_d, fb_q, fb_d;
  logic [7:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             pa_q, pa_d, pb_q, pb_d;
  logic [0:0]       state_q, state_d;
  logic [8:0]       init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d, step_q, step_d, err_q, err_d;

  // Next-state: debounce, INIT absorption, and Gray-code step decode.
  always_comb begin
    state_d            = state_q;
    init_cnt_d         = init_cnt_q;
    {fa_d, cnt_a_d}    = deb_next(sa_q, fa_q, cnt_a_q);
    {fb_d, cnt_b_d}    = deb_next(sb_q, fb_q, cnt_b_q);
    pa_d               = fa_q;
    pb_d               = fb_q;
    q_d                = q_q;
    dir_d              = dir_q;
    step_d             = 1'b0;
    err_d              = err_q;
    case (state_q)
      ST_INIT: begin
        fa_d    = sa_q;
        fb_d    = sb_q;
        cnt_a_d = 8'd0;
        cnt_b_d = 8'd0;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 9'd1;
        end
      end
      ST_RUN: begin
        case ({pa_q, pb_q, fa_q, fb_q})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            q_d    = q_q + ONE;
            dir_d  = 1'b1;
            step_d = 1'b1;
          end
          4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            q_d    = q_q - ONE;
            dir_d  = 1'b0;
            step_d = 1'b1;
          end
          // Both phases moved at once: position is ambiguous, so only flag it.
          4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
            err_d = 1'b1;
          end
          default: begin
            step_d = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta_q   <= 1'b0;
      sa_q       <= 1'b0;
      b_meta_q   <= 1'b0;
      sb_q       <= 1'b0;
      fa_q       <= 1'b0;
      fb_q       <= 1'b0;
      cnt_a_q    <= 8'd0;
      cnt_b_q    <= 8'd0;
      pa_q       <= 1'b0;
      pb_q       <= 1'b0;
      state_q    <= ST_INIT;
      init_cnt_q <= 9'd0;
      q_q        <= {WIDTH{1'b0}};
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      a_meta_q   <= a;
      sa_q       <= a_meta_q;
      b_meta_q   <= b;
      sb_q       <= b_meta_q;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      q_q        <= q_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign q    = q_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scenario bench for quad_decoder: expected steps are queued as stimulus is
// driven and matched against steps captured from the DUT.
module tb_quad_decoder;

  localparam int WIDTH    = 8;
  localparam int DEBOUNCE = 4;
  localparam int LAT      = DEBOUNCE + 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             a     = 1'b0;
  logic             b     = 1'b0;
  logic [WIDTH-1:0] q;
  logic             dir, step, err;

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] obs_q[$];
  int             obs_edge[$];

  logic [1:0] up_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quad_decoder #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .q(q), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Capture every step pulse as {dir,q} plus the edge it came from.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      obs_q.push_back({dir, q});
      obs_edge.push_back(edge_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_edge.delete();
  endtask

  task automatic do_reset(input logic na, input logic nb);
    a = na;
    b = nb;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(LAT + 4);
    clear_sb();
  endtask

  task automatic test_reset();
    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
    cyc(3);
    total++;
    if ({q, dir, step, err} !== {(WIDTH + 3){1'b0}}) begin
      bad++;
      $display("FAIL reset_state: got q=%0d dir=%b step=%b err=%b want all 0", q, dir, step, err);
    end
    reset = 1'b0;
    for (int i = 0; i < LAT + 50; i++) begin
      cyc(1);
      total++;
      if ({q, dir, step, err} !== {(WIDTH + 3){1'b0}}) begin
        bad++;
        $display("FAIL reset_idle cyc %0d: got q=%0d dir=%b step=%b err=%b want all 0", i, q, dir, step, err);
      end
    end
  endtask

  task automatic test_up();
    logic [WIDTH:0] ev, ov;
    int k;
    do_reset(1'b0, 1'b0);
    k = edge_n + 1;
    for (int i = 0; i < 16; i++) begin
      {a, b} = up_seq[i % 4];
      exp_q.push_back({1'b1, 8'(i + 1)});
      cyc(10);
    end
    total++;
    if (obs_edge.size() == 0 || obs_edge[0] != k + LAT) begin
      bad++;
      $display("FAIL up_latency: got edge %0d want %0d", (obs_edge.size() > 0) ? obs_edge[0] : -1, k + LAT);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL up_count: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : {(WIDTH + 1){1'bx}};
      total++;
      if (ov !== ev) begin
        bad++;
        $display("FAIL up_step: got dir/q=%h want %h", ov, ev);
      end
    end
    total++;
    if (q !== 8'd16 || dir !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL up_final: got q=%0d dir=%b err=%b want q=16 dir=1 err=0", q, dir, err);
    end
  endtask

  task automatic test_down();
    logic [WIDTH:0] ev, ov;
    do_reset(1'b0, 1'b0);
    {a, b} = 2'b10;
    exp_q.push_back({1'b0, 8'hFF});
    cyc(10);
    {a, b} = 2'b11;
    exp_q.push_back({1'b0, 8'hFE});
    cyc(10);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL down_count: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : {(WIDTH + 1){1'bx}};
      total++;
      if (ov !== ev) begin
        bad++;
        $display("FAIL down_step: got dir/q=%h want %h", ov, ev);
      end
    end
  endtask

  task automatic test_debounce();
    logic [WIDTH:0] ev, ov;
    do_reset(1'b0, 1'b0);
    a = 1'b1;
    cyc(DEBOUNCE - 1);
    a = 1'b0;
    cyc(12);
    total++;
    if (obs_q.size() != 0 || q !== 8'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL glitch_reject: got steps=%0d q=%0d err=%b want 0 0 0", obs_q.size(), q, err);
    end
    a = 1'b1;
    exp_q.push_back({1'b0, 8'hFF});
    cyc(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL debounce_count: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : {(WIDTH + 1){1'bx}};
      total++;
      if (ov !== ev) begin
        bad++;
        $display("FAIL debounce_step: got dir/q=%h want %h", ov, ev);
      end
    end
  endtask

  task automatic test_illegal();
    logic [WIDTH:0] ev, ov;
    // Reset at 10 so five up steps land on state 00 with q=5.
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      {a, b} = up_seq[(i + 3) % 4];
      exp_q.push_back({1'b1, 8'(i + 1)});
      cyc(10);
    end
    {a, b} = 2'b11;
    cyc(LAT);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_early: got err=%b want 0", err);
    end
    cyc(1);
    total++;
    if (err !== 1'b1 || q !== 8'd5 || dir !== 1'b1 || step !== 1'b0) begin
      bad++;
      $display("FAIL illegal_decode: got err=%b q=%0d dir=%b step=%b want 1 5 1 0", err, q, dir, step);
    end
    cyc(5);
    {a, b} = 2'b10;
    exp_q.push_back({1'b1, 8'd6});
    cyc(10);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL illegal_count: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : {(WIDTH + 1){1'bx}};
      total++;
      if (ov !== ev) begin
        bad++;
        $display("FAIL illegal_step: got dir/q=%h want %h", ov, ev);
      end
    end
    cyc(20);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got err=%b want 1", err);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH:0] ev, ov;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 37; i++) begin
      {a, b} = up_seq[i % 4];
      cyc(8);
    end
    total++;
    if (q !== 8'd37) begin
      bad++;
      $display("FAIL mid_q37: got q=%0d want 37", q);
    end
    {a, b} = 2'b11;
    reset = 1'b1;
    cyc(1);
    total++;
    if (q !== 8'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_edge: got q=%0d err=%b want 0 0", q, err);
    end
    cyc(1);
    reset = 1'b0;
    clear_sb();
    for (int i = 0; i < LAT + 8; i++) begin
      cyc(1);
      total++;
      if (step !== 1'b0 || err !== 1'b0 || q !== 8'd0) begin
        bad++;
        $display("FAIL mid_init cyc %0d: got step=%b err=%b q=%0d want 0 0 0", i, step, err, q);
      end
    end
    {a, b} = 2'b10;
    exp_q.push_back({1'b1, 8'd1});
    cyc(10);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL mid_count: got %0d steps want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      ov = (obs_q.size() > 0) ? obs_q.pop_front() : {(WIDTH + 1){1'bx}};
      total++;
      if (ov !== ev) begin
        bad++;
        $display("FAIL mid_step: got dir/q=%h want %h", ov, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_debounce();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
